sram_heap_banked: RTL and testbench
===================================

# sram_heap_banked

Parametrised successor to the fixed six-SRAM heap. It holds `bank_num` weight/state banks of `node_num` words each. Bank 0 is the dual-port state bank (X); banks 1..bank_num-1 are single-port weight banks. The block fills the banks from off-chip through a valid/ready load port, streams each bank through its own wrapping address counter with a per-bank valid flag, and accepts on-chip write-back into bank 0. It sits between the off-chip loader and the PE array.

## Interface
- `addr_length`, 10, SRAM address width
- `bit_length`, 32, word width
- `bank_num`, 6, number of banks (2..8); bank 0 is dual-port
- `node_num`, 1000, valid words per bank (≤ 2^addr_length); all counters wrap at node_num-1
- `bsel_w`, 3, bank-select width (≥ clog2(bank_num))

Ports:
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `mode`  in  2  00 IDLE, 01 LOAD, 10 RUN, 11 treated as IDLE
- `load_valid`  in  1  off-chip word present
- `load_ready`  out  1  block accepts a load word
- `load_bank`  in  bsel_w  target bank
- `load_addr`  in  addr_length  target address
- `load_data`  in  bit_length  load word
- `load_err`  out  1  sticky: an out-of-range load was dropped
- `rd_en`  in  bank_num  per-bank read request (RUN only)
- `rd_restart`  in  bank_num  per-bank counter restart to 0
- `rd_data`  out  bank_num*bit_length  bank b occupies bits [b*bit_length +: bit_length]
- `rd_valid`  out  bank_num  per-bank data-valid flag
- `wb_valid`  in  1  write `wb_data` into bank 0 port A (RUN only)
- `wb_data`  in  bit_length  write-back word
- `wb_restart`  in  1  write-back counter restart to 0
- `x_collision`  out  1  one-cycle pulse: bank-0 port-A write and port-B read hit the same address

## Operation
- Memories: `SRAM_dual` for bank 0 and `SRAM_SP` per weight bank. Every CEB/WEB/address/data input is driven from a register.
- IDLE: all CEB/WEB are 1. Read counters are forced to 0, the write-back counter is forced to 0, and `load_err` is cleared.
- LOAD:
  - `load_ready` = 1. A transfer occurs on a cycle with `load_valid & load_ready`.
  - If `load_bank < bank_num` and `load_addr < node_num`, the word is written to that bank (port A for bank 0) on the next edge.
  - Otherwise no write occurs and `load_err` is set. It holds until the block enters IDLE or reset.
  - `rd_en`, `wb_valid` and the restart inputs are ignored.
- RUN, per bank b:
  - `rd_restart[b]` sets counter b to 0.
  - `rd_en[b]` reads the word at the current counter value, then increments the counter, with node_num-1 → 0.
  - If both are high, the read is from address 0 and the counter becomes 1.
- RUN write-back: `wb_valid` writes `wb_data` to bank 0 at the write-back counter, which then increments with the same wrap. `wb_restart` has the same priority rule as `rd_restart`.
- Bank 0 port B read and port A write to the same address in the same cycle:
  - `rd_data` for that read is undefined.
  - `x_collision` pulses in the cycle `rd_valid[0]` is asserted for that read.
- Mode change with reads in flight: reads already issued still complete, and their `rd_valid` still asserts. No new requests are taken outside RUN.
- `load_ready` = 0 outside LOAD.

## Timing
- Reset values: `load_ready` 0, `load_err` 0, `rd_valid` all 0, `x_collision` 0, all counters 0, all CEB/WEB 1. `rd_data` is undefined until the first read.
- Read latency is 2:
  - `rd_en[b]` sampled at edge k.
  - The SRAM access is registered at edge k, and the SRAM samples at edge k+1.
  - `rd_data` slice b and `rd_valid[b]` = 1 are visible after edge k+1, for one cycle per request.
- Back-to-back `rd_en` gives one word per cycle, with no bubbles across the wrap.
- Load latency: the word is accepted at edge k and written at edge k+1. It is readable in RUN from edge k+2 onward.
- Write-back latency: accepted at edge k, written at edge k+1.
- `load_err` sets at the edge that accepts the bad transfer.
- Reset asserted mid-transfer: all outputs go to reset values immediately. Pending writes are discarded, and memory contents are not guaranteed.

## Test plan
- Reset, then LOAD of bank 3 addresses 0..3 with 0xA0..0xA3, then RUN with `rd_en[3]` held 4 cycles → `rd_valid[3]` high for 4 cycles starting 2 cycles after the first request; data 0xA0, 0xA1, 0xA2, 0xA3; other `rd_valid` bits stay 0.
- node_num=8; load bank 1 with 0..7; hold `rd_en[1]` for 10 cycles → data 0..7, 0, 1 with no gap.
- `rd_en[2]` for 3 reads, then `rd_restart[2]` and `rd_en[2]` together → 4th read returns the addr-0 word; next read returns addr 1.
- LOAD with `load_bank`=bank_num, then `load_addr`=node_num → both dropped (target contents unchanged); `load_err`=1 and held; IDLE for one cycle → `load_err`=0.
- RUN: `wb_valid` writes 0x55 at addr 0; later read of bank 0 addr 0 → 0x55. A same-address write and read issued in the same cycle → `x_collision` pulses together with that read's `rd_valid[0]`.
- Assert `nrst`=0 for one cycle mid-RUN stream → `rd_valid`=0 immediately; after release, first `rd_en[4]` read returns the addr-0 word.

Source files
------------

// File: rtl/sram_heap_banked.sv
// sram_heap_banked: bank_num SRAM banks between the off-chip loader and the PE array.
// Bank 0 (X, state) is dual-port: port A takes loads and write-back, port B serves reads.
// Banks 1..bank_num-1 are single-port weight banks.
// Every macro input is driven from a register, so the read latency is 2 cycles.
module sram_heap_banked #(
  parameter int addr_length = 10,
  parameter int bit_length  = 32,
  parameter int bank_num    = 6,
  parameter int node_num    = 1000,
  parameter int bsel_w      = 3
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [1:0]                   mode,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [bsel_w-1:0]            load_bank,
  input  logic [addr_length-1:0]       load_addr,
  input  logic [bit_length-1:0]        load_data,
  output logic                         load_err,
  input  logic [bank_num-1:0]          rd_en,
  input  logic [bank_num-1:0]          rd_restart,
  output logic [bank_num*bit_length-1:0] rd_data,
  output logic [bank_num-1:0]          rd_valid,
  input  logic                         wb_valid,
  input  logic [bit_length-1:0]        wb_data,
  input  logic                         wb_restart,
  output logic                         x_collision
);

  // Last valid word address; all counters wrap from here back to 0.
  localparam logic [addr_length-1:0] last_addr = addr_length'(node_num - 1);

  localparam logic [1:0] mode_load = 2'b01;
  localparam logic [1:0] mode_run  = 2'b10;

  // Mode decode; 11 falls through to IDLE behaviour.
  logic in_load;
  logic in_run;

  // Out of reset for at least one edge; keeps load_ready low while reset is held.
  logic active_reg;

  // Load path
  logic load_fire;
  logic load_ok;
  logic [bank_num-1:0] ld_hit;
  logic load_err_reg;
  logic load_err_next;

  // Per-bank read requests and their addresses
  logic [bank_num-1:0]    rd_go;
  logic [addr_length-1:0] rd_addr [bank_num];
  logic [bank_num-1:0]    rd_pend_reg;
  logic [bank_num-1:0]    rd_valid_reg;

  // Write-back path
  logic                   wb_go;
  logic [addr_length-1:0] wb_addr;
  logic [addr_length-1:0] wb_cnt_reg;
  logic [addr_length-1:0] wb_cnt_next;

  // Bank 0 macro input registers
  logic                   x_ceba_reg;
  logic                   x_weba_reg;
  logic [addr_length-1:0] x_aa_reg;
  logic [bit_length-1:0]  x_da_reg;
  logic                   x_cebb_reg;
  logic [addr_length-1:0] x_ab_reg;
  logic [bit_length-1:0]  x_qb;
  logic                   x_collision_reg;

  function automatic logic [addr_length-1:0] wrap_inc(input logic [addr_length-1:0] v);
    return (v == last_addr) ? '0 : v + addr_length'(1);
  endfunction

  assign in_load    = (mode == mode_load);
  assign in_run     = (mode == mode_run);
  assign load_ready = in_load & active_reg;
  assign load_fire  = load_ready & load_valid;
  assign load_ok    = (32'(load_bank) < bank_num) && (32'(load_addr) < node_num);

  assign load_err    = load_err_reg;
  assign rd_valid    = rd_valid_reg;
  assign x_collision = x_collision_reg;

  // Marks the first edge after reset release.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) active_reg <= 1'b0;
    else       active_reg <= 1'b1;
  end

  // Sticky load error: set by a dropped transfer, cleared only in IDLE.
  always_comb begin
    load_err_next = load_err_reg;
    if (!in_load && !in_run)      load_err_next = 1'b0;
    else if (load_fire && !load_ok) load_err_next = 1'b1;
  end

  // Load error register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) load_err_reg <= 1'b0;
    else       load_err_reg <= load_err_next;
  end

  // Read valid pipeline: request registered, macro samples, data out.
  // Not gated by mode so reads already issued still complete.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_pend_reg  <= '0;
      rd_valid_reg <= '0;
    end else begin
      rd_pend_reg  <= rd_go;
      rd_valid_reg <= rd_pend_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < bank_num; gi++) begin : gen_bank
      logic [addr_length-1:0] cnt_reg;
      logic [addr_length-1:0] cnt_next;
      logic [addr_length-1:0] base;

      assign ld_hit[gi]  = load_fire & load_ok & (load_bank == bsel_w'(gi));
      assign rd_go[gi]   = in_run & rd_en[gi];
      // Restart wins: a simultaneous read uses address 0.
      assign base        = rd_restart[gi] ? '0 : cnt_reg;
      assign rd_addr[gi] = base;

      // Read counter: forced to 0 in IDLE, frozen in LOAD, steps on reads in RUN.
      always_comb begin
        cnt_next = cnt_reg;
        if (in_run) begin
          if (rd_en[gi]) cnt_next = wrap_inc(base);
          else           cnt_next = base;
        end else if (!in_load) begin
          cnt_next = '0;
        end
      end

      // Read counter register.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
      end

      if (gi == 0) begin : gen_x
        assign rd_data[0 +: bit_length] = x_qb;
      end else begin : gen_w
        logic                   ceb_reg;
        logic                   web_reg;
        logic [addr_length-1:0] a_reg;
        logic [bit_length-1:0]  d_reg;
        logic [bit_length-1:0]  q;

        // Weight bank port: loads only happen in LOAD, reads only in RUN.
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) begin
            ceb_reg <= 1'b1;
            web_reg <= 1'b1;
            a_reg   <= '0;
            d_reg   <= '0;
          end else begin
            ceb_reg <= ~(ld_hit[gi] | rd_go[gi]);
            web_reg <= ~ld_hit[gi];
            a_reg   <= ld_hit[gi] ? load_addr : rd_addr[gi];
            d_reg   <= load_data;
          end
        end

        SRAM_SP #(
          .addr_w (addr_length),
          .data_w (bit_length)
        ) u_sram (
          .clk (clk),
          .ceb (ceb_reg),
          .web (web_reg),
          .a   (a_reg),
          .d   (d_reg),
          .q   (q)
        );

        assign rd_data[gi*bit_length +: bit_length] = q;
      end
    end
  endgenerate

  assign wb_go   = in_run & wb_valid;
  assign wb_addr = wb_restart ? '0 : wb_cnt_reg;

  // Write-back counter: same restart priority and wrap as the read counters.
  always_comb begin
    wb_cnt_next = wb_cnt_reg;
    if (in_run) begin
      if (wb_valid) wb_cnt_next = wrap_inc(wb_addr);
      else          wb_cnt_next = wb_addr;
    end else if (!in_load) begin
      wb_cnt_next = '0;
    end
  end

  // Write-back counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wb_cnt_reg <= '0;
    else       wb_cnt_reg <= wb_cnt_next;
  end

  // Bank 0 port registers; collision is flagged from the registered ports
  // so it lines up with rd_valid[0] of the affected read.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_ceba_reg      <= 1'b1;
      x_weba_reg      <= 1'b1;
      x_aa_reg        <= '0;
      x_da_reg        <= '0;
      x_cebb_reg      <= 1'b1;
      x_ab_reg        <= '0;
      x_collision_reg <= 1'b0;
    end else begin
      x_ceba_reg      <= ~(ld_hit[0] | wb_go);
      x_weba_reg      <= ~(ld_hit[0] | wb_go);
      x_aa_reg        <= ld_hit[0] ? load_addr : wb_addr;
      x_da_reg        <= ld_hit[0] ? load_data : wb_data;
      x_cebb_reg      <= ~rd_go[0];
      x_ab_reg        <= rd_addr[0];
      x_collision_reg <= ~x_ceba_reg & ~x_weba_reg & ~x_cebb_reg & (x_aa_reg == x_ab_reg);
    end
  end

  SRAM_dual #(
    .addr_w (addr_length),
    .data_w (bit_length)
  ) u_sram_x (
    .clk  (clk),
    .ceba (x_ceba_reg),
    .weba (x_weba_reg),
    .aa   (x_aa_reg),
    .da   (x_da_reg),
    .cebb (x_cebb_reg),
    .ab   (x_ab_reg),
    .qb   (x_qb)
  );

endmodule

// SRAM_SP: single-port synchronous SRAM, active-low enable and write enable.
module SRAM_SP #(
  parameter int addr_w = 10,
  parameter int data_w = 32
) (
  input  logic              clk,
  input  logic              ceb,
  input  logic              web,
  input  logic [addr_w-1:0] a,
  input  logic [data_w-1:0] d,
  output logic [data_w-1:0] q
);
  logic [data_w-1:0] mem [0:(1<<addr_w)-1];

  // Write when enabled with web low, otherwise registered read.
  always_ff @(posedge clk) begin
    if (!ceb) begin
      if (!web) mem[a] <= d;
      else      q      <= mem[a];
    end
  end
endmodule

// SRAM_dual: port A writes, port B reads; same-address access returns undefined data.
module SRAM_dual #(
  parameter int addr_w = 10,
  parameter int data_w = 32
) (
  input  logic              clk,
  input  logic              ceba,
  input  logic              weba,
  input  logic [addr_w-1:0] aa,
  input  logic [data_w-1:0] da,
  input  logic              cebb,
  input  logic [addr_w-1:0] ab,
  output logic [data_w-1:0] qb
);
  logic [data_w-1:0] mem [0:(1<<addr_w)-1];

  // Port A write and port B registered read.
  always_ff @(posedge clk) begin
    if (!ceba && !weba) mem[aa] <= da;
    if (!cebb)          qb      <= mem[ab];
  end
endmodule

// File: tb/tb_sram_heap_banked.sv
// tb_sram_heap_banked: directed checks of load, streaming reads, wrap, restart,
// load errors, write-back, collision flag and asynchronous reset.
module tb_sram_heap_banked;
  localparam int AW = 10;
  localparam int BW = 32;
  localparam int NB = 6;
  localparam int NN = 8;
  localparam int SW = 3;

  logic               clk = 1'b0;
  logic               nrst;
  logic [1:0]         mode;
  logic               load_valid;
  logic               load_ready;
  logic [SW-1:0]      load_bank;
  logic [AW-1:0]      load_addr;
  logic [BW-1:0]      load_data;
  logic               load_err;
  logic [NB-1:0]      rd_en;
  logic [NB-1:0]      rd_restart;
  logic [NB*BW-1:0]   rd_data;
  logic [NB-1:0]      rd_valid;
  logic               wb_valid;
  logic [BW-1:0]      wb_data;
  logic               wb_restart;
  logic               x_collision;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_words [16];

  sram_heap_banked #(
    .addr_length (AW),
    .bit_length  (BW),
    .bank_num    (NB),
    .node_num    (NN),
    .bsel_w      (SW)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .mode        (mode),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_bank   (load_bank),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err),
    .rd_en       (rd_en),
    .rd_restart  (rd_restart),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_restart  (wb_restart),
    .x_collision (x_collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slice(input int b);
    return rd_data[b*BW +: BW];
  endfunction

  task automatic load_word(input int b, input int a, input logic [31:0] d);
    load_valid = 1'b1;
    load_bank  = SW'(b);
    load_addr  = AW'(a);
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  // n back-to-back reads of bank b; request index rs also restarts (-1: none).
  task automatic read_stream(input int b, input int n, input int rs, input string tag);
    rd_en = '0;
    rd_restart = '0;
    rd_en[b] = 1'b1;
    rd_restart[b] = (rs == 0);
    for (int j = 1; j <= n + 2; j++) begin
      tick();
      rd_en[b] = (j < n);
      rd_restart[b] = (j < n) && (j == rs);
      if (j >= 2 && j <= n + 1) begin
        check($sformatf("%s valid[%0d]", tag, j - 2), 32'(rd_valid), 32'(1) << b);
        check($sformatf("%s data[%0d]", tag, j - 2), slice(b), exp_words[j - 2]);
      end else begin
        check($sformatf("%s quiet@%0d", tag, j), 32'(rd_valid), 32'd0);
      end
    end
  endtask

  initial begin
    nrst = 1'b0; mode = 2'b00; load_valid = 1'b0; load_bank = '0; load_addr = '0;
    load_data = '0; rd_en = '0; rd_restart = '0; wb_valid = 1'b0; wb_data = '0;
    wb_restart = 1'b0;
    tick();
    tick();
    check("reset load_ready", 32'(load_ready), 32'd0);
    check("reset load_err", 32'(load_err), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset x_collision", 32'(x_collision), 32'd0);
    nrst = 1'b1;
    tick();

    // Fill banks
    mode = 2'b01;
    for (int i = 0; i < 4; i++) load_word(3, i, 32'hA0 + 32'(i));
    for (int i = 0; i < NN; i++) begin
      load_word(1, i, 32'(i));
      load_word(2, i, 32'h20 + 32'(i));
      load_word(4, i, 32'h40 + 32'(i));
    end
    check("load_ready in LOAD", 32'(load_ready), 32'd1);
    check("load_err after good loads", 32'(load_err), 32'd0);
    mode = 2'b00;
    tick();

    // Bank 3 stream of 4
    mode = 2'b10;
    #1;
    check("load_ready in RUN", 32'(load_ready), 32'd0);
    for (int i = 0; i < 4; i++) exp_words[i] = 32'hA0 + 32'(i);
    read_stream(3, 4, -1, "b3");

    // Bank 1 wrap: 0..7,0,1
    for (int i = 0; i < 10; i++) exp_words[i] = 32'(i % NN);
    read_stream(1, 10, -1, "b1 wrap");

    // Bank 2 restart on the 4th read
    exp_words[0] = 32'h20; exp_words[1] = 32'h21; exp_words[2] = 32'h22;
    exp_words[3] = 32'h20; exp_words[4] = 32'h21;
    read_stream(2, 5, 3, "b2 restart");

    // Out-of-range loads
    mode = 2'b01;
    load_word(NB, 0, 32'hDEADBEEF);
    check("load_err bad bank", 32'(load_err), 32'd1);
    load_word(1, NN, 32'hBAD00001);
    check("load_err bad addr", 32'(load_err), 32'd1);
    load_word(5, 0, 32'h5A);
    check("load_err held", 32'(load_err), 32'd1);
    mode = 2'b00;
    tick();
    check("load_err cleared in IDLE", 32'(load_err), 32'd0);
    mode = 2'b10;
    exp_words[0] = 32'd0;
    read_stream(1, 1, -1, "b1 untouched");
    exp_words[0] = 32'h5A;
    read_stream(5, 1, -1, "b5 good load");

    // Write-back 0x55 at addr 0, then read it back
    wb_valid = 1'b1; wb_data = 32'h55;
    tick();
    wb_valid = 1'b0;
    tick();
    exp_words[0] = 32'h55;
    read_stream(0, 1, -1, "b0 wb");

    // Write addr 1 while reading addr 0: no collision
    rd_en[0] = 1'b1; rd_restart[0] = 1'b1; wb_valid = 1'b1; wb_data = 32'h77;
    tick();
    rd_en = '0; rd_restart = '0; wb_valid = 1'b0;
    check("nocoll x_collision@1", 32'(x_collision), 32'd0);
    tick();
    check("nocoll rd_valid", 32'(rd_valid), 32'd1);
    check("nocoll data", slice(0), 32'h55);
    check("nocoll x_collision@2", 32'(x_collision), 32'd0);

    // Same-address write and read
    rd_en[0] = 1'b1; rd_restart[0] = 1'b1; wb_valid = 1'b1; wb_restart = 1'b1; wb_data = 32'h66;
    tick();
    rd_en = '0; rd_restart = '0; wb_valid = 1'b0; wb_restart = 1'b0;
    check("coll x_collision@1", 32'(x_collision), 32'd0);
    tick();
    check("coll rd_valid", 32'(rd_valid), 32'd1);
    check("coll x_collision@2", 32'(x_collision), 32'd1);
    tick();
    check("coll x_collision@3", 32'(x_collision), 32'd0);
    exp_words[0] = 32'h66; exp_words[1] = 32'h77;
    read_stream(0, 2, 0, "b0 wb contents");

    // Read in flight across a switch to IDLE
    rd_en[3] = 1'b1; rd_restart[3] = 1'b1;
    tick();
    rd_en = '0; rd_restart = '0; mode = 2'b00;
    tick();
    check("inflight rd_valid", 32'(rd_valid), 32'h8);
    check("inflight data", slice(3), 32'hA0);
    tick();
    check("inflight done", 32'(rd_valid), 32'd0);

    // Reset in the middle of a bank-4 stream
    mode = 2'b10;
    rd_en[4] = 1'b1;
    tick();
    tick();
    tick();
    check("pre-reset rd_valid", 32'(rd_valid), 32'h10);
    check("pre-reset data", slice(4), 32'h41);
    nrst = 1'b0;
    #1;
    check("async reset rd_valid", 32'(rd_valid), 32'd0);
    rd_en = '0;
    tick();
    nrst = 1'b1;
    exp_words[0] = 32'h40; exp_words[1] = 32'h41;
    read_stream(4, 2, -1, "b4 after reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
